// File: rtl/alu_pkg.sv
// Shared ALUOp codes and control states for the sequential N-bit ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier datapath: one partial product per step, fixed WIDTH steps.
module alu_mul_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_accNext
);

  logic [WIDTH-1:0] r_multiplicand;
  logic [WIDTH-1:0] r_multiplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;

  // The accumulator value after this step is what the top latches on the final step.
  assign o_accNext = r_acc + (r_multiplier[0] ? r_multiplicand : '0);
  assign o_last    = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_multiplicand <= '0;
      r_multiplier   <= '0;
      r_acc          <= '0;
      r_count        <= '0;
    end else if (i_load) begin
      r_multiplicand <= i_a;
      r_multiplier   <= i_b;
      r_acc          <= '0;
      r_count        <= '0;
    end else if (i_step) begin
      r_acc          <= o_accNext;
      r_multiplicand <= r_multiplicand << 1;
      r_multiplier   <= r_multiplier >> 1;
      r_count        <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_nbit_seq.sv
// N-bit EX-stage ALU: single-cycle logic/arith/compare ops plus an iterative multiply
// behind a start/done handshake.
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t r_state;
  state_t w_nextState;

  logic             w_accept;
  logic             w_isMul;
  logic             w_mulLast;
  logic [WIDTH-1:0] w_mulAcc;

  logic [WIDTH-1:0] w_aIn;
  logic [WIDTH-1:0] w_bIn;
  logic [WIDTH:0]   w_sum;
  logic             w_addOvf;
  logic [WIDTH-1:0] w_opResult;
  logic             w_opCarry;
  logic             w_opOvf;
  logic             w_opIllegal;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic             r_illegal;

  assign w_accept = start && (r_state != S_MUL);
  assign w_isMul  = (ALUOp == OP_MUL);

  // The legacy bit-slice encoding: invert A, negate B (carry-in = ALUOp[2]).
  assign w_aIn    = ALUOp[3] ? ~a : a;
  assign w_bIn    = ALUOp[2] ? ~b : b;
  assign w_sum    = {1'b0, w_aIn} + {1'b0, w_bIn} + {{WIDTH{1'b0}}, ALUOp[2]};
  assign w_addOvf = (w_aIn[WIDTH-1] == w_bIn[WIDTH-1]) && (w_sum[WIDTH-1] != w_aIn[WIDTH-1]);

  always_comb begin
    w_opResult  = '0;
    w_opCarry   = 1'b0;
    w_opOvf     = 1'b0;
    w_opIllegal = 1'b0;
    case (ALUOp)
      OP_AND, OP_NOR: w_opResult = w_aIn & w_bIn;
      OP_OR:          w_opResult = w_aIn | w_bIn;
      OP_ADD, OP_SUB: begin
        w_opResult = w_sum[WIDTH-1:0];
        w_opCarry  = w_sum[WIDTH];
        w_opOvf    = w_addOvf;
      end
      OP_SLT:         w_opResult = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_addOvf};
      default:        w_opIllegal = 1'b1;
    endcase
  end

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept && w_isMul),
    .i_step    (r_state == S_MUL),
    .i_a       (a),
    .i_b       (b),
    .o_last    (w_mulLast),
    .o_accNext (w_mulAcc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_MUL: begin
        if (w_mulLast) begin
          w_nextState = S_DONE;
        end
      end
      default: begin
        if (w_accept) begin
          w_nextState = w_isMul ? S_MUL : S_DONE;
        end else begin
          w_nextState = S_IDLE;
        end
      end
    endcase
  end

  // Results only change on a completion so they stay stable between done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_isMul) begin
      r_result  <= w_opResult;
      r_zero    <= (w_opResult == '0);
      r_carry   <= w_opCarry;
      r_ovf     <= w_opOvf;
      r_illegal <= w_opIllegal;
    end else if ((r_state == S_MUL) && w_mulLast) begin
      r_result  <= w_mulAcc;
      r_zero    <= (w_mulAcc == '0);
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  assign busy     = (r_state == S_MUL);
  assign done     = (r_state == S_DONE);
  assign illegal  = done && r_illegal;
  assign Result   = r_result;
  assign Zero     = r_zero;
  assign CarryOut = r_carry;
  assign Overflow = r_ovf;

endmodule

// File: doc/alu_nbit_seq.md
Name: alu_nbit_seq

Overview:
- Parametrised N-bit ALU; successor to the bit-sliced single-cycle ALU in the datapath.
- Keeps the existing 4-bit ALUOp encoding: ALUOp[3] inverts A, ALUOp[2] negates B, ALUOp[1:0] selects AND/OR/ADD.
- Adds SLT, NOR, a registered start/done handshake, and an iterative shift-add multiplier.
- Sits in the EX stage; the control unit stalls on busy.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range ≥ 4.
- CNT_W, $clog2(WIDTH), width of the multiplier iteration counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- ALUOp  input  4  operation code, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while a multiply is iterating.
- done  output  1  one-cycle pulse when Result/flags update.
- Result  output  WIDTH  registered result; holds until next completion.
- Zero  output  1  registered, Result==0.
- CarryOut  output  1  registered carry; meaningful for ADD/SUB only, otherwise 0.
- Overflow  output  1  registered signed overflow; ADD/SUB only, otherwise 0.
- illegal  output  1  pulses with done for unsupported ALUOp.

Behaviour:
- Reset (async, any state) forces:
  - state=IDLE.
  - busy=0, done=0, illegal=0.
  - Result=0, Zero=1, CarryOut=0, Overflow=0.
  - Iteration counter=0.
- An in-flight multiply is abandoned on reset.
- Encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A + ~B + 1).
  - 0111 SLT: Result = {0…, signed(a)<signed(b)}, from the SUB sign XOR overflow.
  - 1100 NOR (~A & ~B).
  - 1000 MUL: low WIDTH bits of a*b, unsigned/two's-complement identical.
  - Any other code: illegal.
- State machine IDLE / MUL / DONE; busy = (state==MUL).
- Accept: start=1 while state is IDLE or DONE. start while busy is ignored and not queued.
- Single-cycle ops (all but MUL):
  - If accepted in cycle t, Result and flags are written at the end of cycle t.
  - State goes to DONE; done=1 in cycle t+1.
  - Back-to-back: start every cycle gives done every cycle.
- MUL:
  - When accepted in cycle t: latch multiplicand=a, multiplier=b, acc=0, counter=0, state=MUL.
  - Each MUL cycle: if multiplier[0], acc += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter++.
  - On the iteration with counter==WIDTH-1: write Result=acc-next and go to DONE.
  - done=1 in cycle t+WIDTH+1.
  - busy is high in cycles t+1..t+WIDTH.
  - There is no early termination; latency is fixed.
- DONE lasts exactly one cycle. Next state is IDLE, unless start is accepted there, which follows the rules above.
- Flags on completion:
  - Zero always reflects the new Result.
  - CarryOut and Overflow are updated only for ADD/SUB and are cleared for all other ops.
  - SLT, NOR and MUL clear CarryOut/Overflow.
- Illegal op:
  - Result=0, Zero=1, CarryOut=0, Overflow=0.
  - done and illegal pulse together in cycle t+1.
- Result and flags are stable between done pulses. Input changes while busy have no effect.

Decomposition:
- Package alu_pkg holds:
  - ALUOp constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL).
  - State enum (S_IDLE, S_MUL, S_DONE).
- One sub-module, alu_mul_seq, contains the shift-add datapath. Its interface is load/step/last, with operands, counter and acc inside it.
- The combinational AND/OR/ADD/SUB/SLT/NOR path stays in the top level.

Test Plan (WIDTH=8 unless stated):
- ADD, SUB, flags. Each row is stimulus -> required response:
  - ADD a=0x7F, b=0x01 -> done at t+1; Result=0x80, Overflow=1, CarryOut=0, Zero=0.
  - SUB a=0x05, b=0x05 -> Result=0x00, Zero=1, CarryOut=1, Overflow=0.
  - AND 0xF0&0x3C -> Result=0x30, CarryOut=0.
- Logic and compare:
  - NOR 0x0F,0xF0 -> Result=0x00, Zero=1.
  - SLT a=0xFE(-2), b=0x01 -> Result=0x01.
  - SLT a=0x01, b=0xFE -> Result=0x00.
- Multiply:
  - MUL a=0x0D, b=0x0B accepted at t -> busy high t+1..t+8; done at t+9; Result=0x8F.
  - MUL a=0x10, b=0x10 -> Result=0x00, Zero=1.
- Handshake:
  - start with ADD pulsed during MUL busy -> ignored; only one done, carrying the MUL result.
  - Back-to-back ADD, OR, SUB on consecutive cycles -> three consecutive done pulses with the correct Results.
- Illegal op and reset:
  - ALUOp=0101 -> done and illegal both high at t+1; Result=0, Zero=1.
  - reset asserted asynchronously mid-MUL (cycle t+4) -> busy/done drop immediately; Result=0; next start proceeds normally.
- WIDTH=64 smoke test: MUL 0xFFFF_FFFF_FFFF_FFFF × 2 -> done at t+65; Result=0xFFFF_FFFF_FFFF_FFFE.
